// File: rtl/output_line_buffer_pkg.sv
// ----------------------------------------------------------------------------
// output_line_buffer_pkg
//   Shared definitions for the conv2d output line buffer: row-pass FSM states,
//   default geometry / number-format constants, and saturation bound helpers
//   expressed as functions of the output pixel width.
//   No ports (package).
// ----------------------------------------------------------------------------
package output_line_buffer_pkg;

    localparam int OLB_MAX_IMAGE_SIZE = 128;
    localparam int OLB_DATA_WIDTH     = 16;
    localparam int OLB_ACC_WIDTH      = 32;
    localparam int OLB_FRAC_SHIFT     = 8;

    // Output FIFO depth; the skid FIFO pointer logic is written for exactly 2.
    localparam int OLB_FIFO_DEPTH     = 2;

    typedef enum logic {
        S_ROW     = 1'b0,   // accepting conv results for the current row pass
        S_ROW_END = 1'b1    // one bubble cycle: Done_1row pulse, column rewind
    } olb_state_e;

    // Largest representable signed value of a dw-bit output pixel.
    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - longint'(1);
    endfunction

    // Smallest representable signed value of a dw-bit output pixel.
    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/output_line_buffer_fifo.sv
// ----------------------------------------------------------------------------
// output_line_buffer_fifo
//   Two-entry skid FIFO feeding the AXI4-Stream master port. Push and pop in
//   the same cycle are allowed even when full: the slot being popped is the
//   slot being overwritten, so the head read and the new write never clash.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (empties FIFO)
//     push/push_data  write one entry (caller guarantees space or a pop)
//     count           current occupancy 0..2
//     out_valid/out_data/out_ready  head entry with valid/ready handshake
// ----------------------------------------------------------------------------
module output_line_buffer_fifo
    import output_line_buffer_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [1:0]   count,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [W-1:0] mem_q [OLB_FIFO_DEPTH];
    logic [W-1:0] mem_d [OLB_FIFO_DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop;
    logic         push_ok;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign pop       = out_valid && out_ready;
    // Drop a push that would overflow; upstream gating should never cause one.
    assign push_ok   = push && ((count_q != 2'(OLB_FIFO_DEPTH)) || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop};
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Entries cleared so tdata reads as zero out of reset.
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/output_line_buffer.sv
// ----------------------------------------------------------------------------
// output_line_buffer
//   Output side of the conv2d datapath. Per-pixel partial sums from the MAC
//   array are accumulated across input channels in a one-row buffer. On the
//   final channel pass each pixel is requantized (arithmetic shift right by
//   FRAC_SHIFT, saturate to DATA_WIDTH) and streamed out as AXI4-Stream.
//
//   Optional feature macro: OUTPUT_RELU_EN
//     defined   -> negative sums are clamped to 0 before shift/saturation
//     undefined -> signed pass-through, negative pixels are emitted
//
//   Ports:
//     clk, Reset          clock, synchronous active-high reset
//     IMAGE_SIZE          row length and row count (3..MAX_IMAGE_SIZE)
//     first_channel       pass is channel 0: overwrite instead of accumulate
//     last_channel        pass is final channel: emit instead of store
//     conv_result/valid   signed partial sum from MAC array
//     conv_ready          result accepted this cycle when also valid
//     Done_1row           one-cycle pulse after a row pass completes
//     m_axis_*            AXI4-Stream master (tdata, tvalid, tlast, tready)
// ----------------------------------------------------------------------------
module output_line_buffer
    import output_line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = OLB_DATA_WIDTH,
    parameter int ACC_WIDTH      = OLB_ACC_WIDTH,
    parameter int MAX_IMAGE_SIZE = OLB_MAX_IMAGE_SIZE,
    parameter int FRAC_SHIFT     = OLB_FRAC_SHIFT
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [7:0]                  IMAGE_SIZE,
    input  logic                        first_channel,
    input  logic                        last_channel,
    input  logic signed [ACC_WIDTH-1:0] conv_result,
    input  logic                        conv_valid,
    output logic                        conv_ready,
    output logic                        Done_1row,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready
);

    // IMAGE_SIZE is 8 bits, so the column address never needs more than that.
    localparam int ADDR_W = $clog2(MAX_IMAGE_SIZE);

    localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

    olb_state_e state_q, state_d;
    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;

    logic signed [ACC_WIDTH-1:0] rowbuf_q [MAX_IMAGE_SIZE];
    logic                        rowbuf_we;
    logic [ADDR_W-1:0]           rowbuf_addr;
    logic signed [ACC_WIDTH-1:0] rowbuf_d;

    logic                        accept;
    logic                        last_col;
    logic                        last_row;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] q_in;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]       qdata;

    logic                        fifo_push;
    logic                        fifo_push_tlast;
    logic [1:0]                  fifo_count;
    logic [DATA_WIDTH:0]         fifo_out;

    // ------------------------------------------------------------------
    // Flow control. Only the emitting pass depends on FIFO space; a full
    // FIFO still accepts when the head leaves in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        conv_ready = (state_q == S_ROW) &&
                     (!last_channel || (fifo_count < 2'd2) ||
                      ((fifo_count == 2'd2) && m_axis_tready));
    end

    assign accept      = conv_valid && conv_ready;
    assign last_col    = (col_q == (IMAGE_SIZE - 8'd1));
    assign last_row    = (row_q == (IMAGE_SIZE - 8'd1));
    assign rowbuf_addr = col_q[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Accumulate and requantize. Accumulation wraps in ACC_WIDTH; only the
    // emitted value is saturated.
    // ------------------------------------------------------------------
    always_comb begin
        sum = first_channel ? conv_result : (rowbuf_q[rowbuf_addr] + conv_result);

        q_in = sum;
`ifdef OUTPUT_RELU_EN
        if (sum < 0) begin
            q_in = '0;
        end
`endif
        shifted = q_in >>> FRAC_SHIFT;

        if (shifted > Q_MAX) begin
            qdata = Q_MAX[DATA_WIDTH-1:0];
        end else if (shifted < Q_MIN) begin
            qdata = Q_MIN[DATA_WIDTH-1:0];
        end else begin
            qdata = shifted[DATA_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Row-pass FSM with column/row counters.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        Done_1row       = 1'b0;
        rowbuf_we       = 1'b0;
        rowbuf_d        = sum;
        fifo_push       = 1'b0;
        fifo_push_tlast = 1'b0;

        case (state_q)
            S_ROW: begin
                if (accept) begin
                    if (last_channel) begin
                        fifo_push       = 1'b1;
                        fifo_push_tlast = last_col && last_row;
                    end else begin
                        rowbuf_we = 1'b1;
                    end

                    if (last_col) begin
                        // Column is rewound in the bubble cycle that follows.
                        state_d = S_ROW_END;
                        if (last_channel) begin
                            row_d = last_row ? 8'd0 : (row_q + 8'd1);
                        end
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end

            S_ROW_END: begin
                Done_1row = 1'b1;
                col_d     = 8'd0;
                state_d   = S_ROW;
            end

            default: begin
                state_d = S_ROW;
                col_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_ROW;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Row buffer has no reset: channel 0 always overwrites before any read.
    always_ff @(posedge clk) begin
        if (rowbuf_we) begin
            rowbuf_q[rowbuf_addr] <= rowbuf_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO; tlast travels with the pixel in the top bit.
    // ------------------------------------------------------------------
    output_line_buffer_fifo #(
        .W (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (Reset),
        .push      (fifo_push),
        .push_data ({fifo_push_tlast, qdata}),
        .count     (fifo_count),
        .out_valid (m_axis_tvalid),
        .out_data  (fifo_out),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tdata = fifo_out[DATA_WIDTH-1:0];
    assign m_axis_tlast = fifo_out[DATA_WIDTH];

endmodule

// File: tb/tb_output_line_buffer.sv
// Scoreboard bench: the driver pushes expected beats as pixels are accepted,
// a monitor pops and compares on every AXI handshake.
module tb_output_line_buffer;

    logic               clk = 1'b0;
    logic               Reset;
    logic [7:0]         IMAGE_SIZE;
    logic               first_channel;
    logic               last_channel;
    logic signed [31:0] conv_result;
    logic               conv_valid;
    logic               conv_ready;
    logic               Done_1row;
    logic [15:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic               m_axis_tready;

    always #5 clk = ~clk;

    output_line_buffer #(
        .DATA_WIDTH     (16),
        .ACC_WIDTH      (32),
        .MAX_IMAGE_SIZE (128),
        .FRAC_SHIFT     (8)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .IMAGE_SIZE    (IMAGE_SIZE),
        .first_channel (first_channel),
        .last_channel  (last_channel),
        .conv_result   (conv_result),
        .conv_valid    (conv_valid),
        .conv_ready    (conv_ready),
        .Done_1row     (Done_1row),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t              sb[$];
    int                 checks = 0;
    int                 failures = 0;
    int                 done_cnt = 0;
    int                 tlast_cnt = 0;
    int                 acc_cnt = 0;
    int                 quiet_viol = 0;
    bit                 quiet = 1'b0;
    bit                 rand_ready = 1'b0;
    bit                 gap_en = 1'b0;
    logic signed [31:0] m_acc [128];
    int                 m_row = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference requantization: >>>8 then clamp to signed 16 bits.
    function automatic logic [15:0] ref_quant(input logic signed [31:0] s);
        logic signed [31:0] sh;
        sh = s >>> 8;
`ifdef OUTPUT_RELU_EN
        if (s < 0) sh = 0;
`endif
        if (sh > 32767)  return 16'h7fff;
        if (sh < -32768) return 16'h8000;
        return sh[15:0];
    endfunction

    function automatic logic signed [31:0] pix(input int mode, input int col);
        case (mode)
            0: return 32'(256 * (col + 1));
            1: return 32'sd256;
            2: begin
                case (col)
                    0:       return 32'sh7fff_0000;
                    1:       return 32'sh8000_0000;
                    default: return 32'sd256;
                endcase
            end
            default: return 32'(int'($urandom_range(0, 1048576)) - 524288);
        endcase
    endfunction

    // Hand-derived outputs for the directed patterns.
    function automatic logic [15:0] hand_exp(input int mode, input int col, input int nch);
        case (mode)
            0: return 16'(col + 1);
            1: return 16'(nch);
            default: begin
                case (col)
                    0: return 16'h7fff;
`ifdef OUTPUT_RELU_EN
                    1: return 16'h0000;
`else
                    1: return 16'h8000;
`endif
                    default: return 16'h0001;
                endcase
            end
        endcase
    endfunction

    // Monitor: scoreboard pops, AXI hold rule, pulse/accept counters.
    initial begin
        logic        prev_hold;
        logic [16:0] prev_beat;
        beat_t       b;
        prev_hold = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            if (Reset) begin
                prev_hold = 1'b0;
            end else begin
                if (Done_1row) done_cnt++;
                if (conv_valid && conv_ready) acc_cnt++;
                if (quiet && m_axis_tvalid) quiet_viol++;
                if (prev_hold) begin
                    check("axi_hold_valid", 64'(m_axis_tvalid), 64'd1);
                    check("axi_hold_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_beat));
                end
                prev_hold = m_axis_tvalid && !m_axis_tready;
                prev_beat = {m_axis_tlast, m_axis_tdata};
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h expected=none", m_axis_tdata);
                    end else begin
                        b = sb.pop_front();
                        check("tdata", 64'(m_axis_tdata), 64'(b.d));
                        check("tlast", 64'(m_axis_tlast), 64'(b.l));
                    end
                    if (m_axis_tlast) tlast_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic send_pixel(input logic signed [31:0] v, output bit ok);
        int t;
        if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        conv_result = v;
        conv_valid  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!conv_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = conv_ready;
        check("accept_ready", 64'(conv_ready), 64'd1);
        @(posedge clk); #1;
        conv_valid = 1'b0;
    endtask

    task automatic run_image(input int n, input int nch, input int mode);
        logic signed [31:0] v, s;
        beat_t b;
        bit ok;
        IMAGE_SIZE = 8'(n);
        for (int r = 0; r < n; r++) begin
            for (int ch = 0; ch < nch; ch++) begin
                first_channel = (ch == 0);
                last_channel  = (ch == nch - 1);
                if (!last_channel && mode == 1) begin
                    wait_drain();
                    quiet = 1'b1;
                end else begin
                    quiet = 1'b0;
                end
                for (int c = 0; c < n; c++) begin
                    v = pix(mode, c);
                    s = (ch == 0) ? v : (m_acc[c] + v);
                    send_pixel(v, ok);
                    if (ok) begin
                        if (!last_channel) begin
                            m_acc[c] = s;
                        end else begin
                            b.d = (mode == 3) ? ref_quant(s) : hand_exp(mode, c, nch);
                            b.l = (c == n - 1) && (m_row == n - 1);
                            sb.push_back(b);
                        end
                    end
                end
                if (last_channel) m_row = (m_row == n - 1) ? 0 : m_row + 1;
            end
        end
        quiet = 1'b0;
        wait_drain();
    endtask

    initial begin
        int t;
        Reset         = 1'b1;
        IMAGE_SIZE    = 8'd4;
        first_channel = 1'b0;
        last_channel  = 1'b0;
        conv_result   = '0;
        conv_valid    = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_done", 64'(Done_1row), 64'd0);
        check("rst_conv_ready", 64'(conv_ready), 64'd1);
        @(posedge clk); #1;

        // Single channel, 4x4, ramp per column.
        done_cnt = 0; tlast_cnt = 0;
        run_image(4, 1, 0);
        check("single_done_pulses", 64'(done_cnt), 64'd4);
        check("single_tlast_count", 64'(tlast_cnt), 64'd1);

        // Three channels of 256: every output is 3, silent on early passes.
        tlast_cnt = 0; quiet_viol = 0;
        run_image(4, 3, 1);
        check("multi_quiet", 64'(quiet_viol), 64'd0);
        check("multi_tlast_count", 64'(tlast_cnt), 64'd1);

        // Saturation at both ends.
        tlast_cnt = 0;
        run_image(3, 1, 2);
        check("sat_tlast_count", 64'(tlast_cnt), 64'd1);

        // Backpressure during an emitting pass: only two pixels get in.
        tlast_cnt = 0; acc_cnt = 0;
        m_axis_tready = 1'b0;
        fork
            run_image(4, 1, 0);
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                check("stall_accepts", 64'(acc_cnt), 64'd2);
                check("stall_conv_ready", 64'(conv_ready), 64'd0);
                check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                @(posedge clk); #1;
                m_axis_tready = 1'b1;
            end
        join
        check("stall_tlast_count", 64'(tlast_cnt), 64'd1);

        // Random valid gaps and tready, 8x8, 4 channels.
        tlast_cnt = 0;
        rand_ready = 1'b1; gap_en = 1'b1;
        run_image(8, 4, 3);
        rand_ready = 1'b0; gap_en = 1'b0;
        m_axis_tready = 1'b1;
        check("rand_tlast_count", 64'(tlast_cnt), 64'd1);

        // Reset in the middle of an emitting pass with the FIFO full.
        IMAGE_SIZE    = 8'd4;
        m_axis_tready = 1'b0;
        first_channel = 1'b1;
        last_channel  = 1'b1;
        conv_result   = 32'sd256;
        acc_cnt       = 0;
        conv_valid    = 1'b1;
        t = 0;
        @(negedge clk);
        while (acc_cnt < 2 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        conv_valid = 1'b0;
        @(negedge clk);
        check("prereset_fifo_full_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("prereset_conv_ready", 64'(conv_ready), 64'd0);
        @(posedge clk); #1;
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_done", 64'(Done_1row), 64'd0);
        @(posedge clk); #1;
        Reset = 1'b0;
        m_axis_tready = 1'b1;
        sb.delete();
        m_row = 0;
        tlast_cnt = 0; done_cnt = 0;
        run_image(4, 1, 0);
        check("postrst_tlast_count", 64'(tlast_cnt), 64'd1);
        check("postrst_done_pulses", 64'(done_cnt), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_line_buffer.md
# output_line_buffer

Output-side counterpart of the Conv2d input line buffer: accepts per-pixel convolution results from the MAC array, accumulates partial sums across input channels in a one-row buffer, and on the last channel requantizes each pixel and emits it as an AXI4-Stream master. It sits between the MAC array and the output DMA and closes the stream path that begins at the input line buffer.

## Interface
- DATA_WIDTH, 16, output pixel width (signed)
- ACC_WIDTH, 32, partial-sum and conv_result width (signed)
- MAX_IMAGE_SIZE, 128, row buffer depth
- FRAC_SHIFT, 8, arithmetic right shift applied before saturation
- clk  input  1  single clock, rising edge
- Reset  input  1  synchronous, active-high
- IMAGE_SIZE  input  8  row length and row count; valid 3..MAX_IMAGE_SIZE, static while not idle
- first_channel  input  1  current row pass is input channel 0 (overwrite, no add)
- last_channel  input  1  current row pass is final channel (emit)
- conv_result  input  ACC_WIDTH  signed pixel partial sum
- conv_valid  input  1  conv_result valid
- conv_ready  output  1  block accepts conv_result this cycle
- Done_1row  output  1  one-cycle pulse after the last pixel of a row pass is accepted
- m_axis_tdata  output  DATA_WIDTH  output pixel
- m_axis_tvalid  output  1  AXI-Stream valid
- m_axis_tlast  output  1  last pixel of the image
- m_axis_tready  input  1  AXI-Stream ready from downstream

## Operation
- Accept = conv_valid && conv_ready. first_channel/last_channel sampled at each accept, held constant by upstream within a row pass.
- Column counter col (0..IMAGE_SIZE-1) addresses row buffer; increments per accept.
- Per accept: sum = first_channel ? conv_result : rowbuf[col] + conv_result (ACC_WIDTH two's-complement wrap, no saturation). If !last_channel: rowbuf[col] <= sum. If last_channel: push quant(sum) into output FIFO; rowbuf untouched.
- quant: (sum >>> FRAC_SHIFT) saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output FIFO: 2 entries. conv_ready = (state==S_ROW) && (!last_channel || fifo_count<2 || (fifo_count==2 && m_axis_tready)) — simultaneous push and pop at full is allowed.
- Row counter row (0..IMAGE_SIZE-1) increments at end of each last_channel pass; tlast tagged on the FIFO entry for col==IMAGE_SIZE-1 && row==IMAGE_SIZE-1; row then wraps to 0.
- FSM: S_ROW (accepting) -> S_ROW_END when accept at col==IMAGE_SIZE-1; S_ROW_END: Done_1row=1, conv_ready=0, col<=0 -> S_ROW.
- Reset: state S_ROW, col=0, row=0, FIFO empty. Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, Done_1row=0. Row buffer contents not reset (first_channel overwrites). Reset mid-row discards in-flight FIFO data.

## Timing
- Accept at cycle N with last_channel: entry visible at FIFO output cycle N+1; if FIFO was empty, m_axis_tvalid=1 at N+1.
- Non-last accept: rowbuf written at N+1 edge; back-to-back accepts at same col not possible.
- Done_1row asserted in cycle after final accept of a row; sustained throughput IMAGE_SIZE pixels per IMAGE_SIZE+1 cycles.
- AXI: tdata/tlast stable while tvalid && !tready; tvalid never drops without handshake.
- m_axis_tready low: non-last passes proceed unaffected; last pass stalls after 2 buffered pixels.

## Configuration
- OUTPUT_RELU_EN: defined -> sum clamped to 0 when negative before shift/saturation. Undefined -> signed pass-through; negative outputs emitted.

## Structure
- Shared conv2d package: state enum (S_ROW, S_ROW_END), saturation bounds as functions of DATA_WIDTH, MAX_IMAGE_SIZE constant.
- One sub-module: output_line_buffer_fifo (2-entry skid FIFO, DATA_WIDTH+1 wide for tlast). Row buffer, counters, FSM inline.

## Test plan
- IMAGE_SIZE=4, single channel (first=last=1), results 256,512,768,1024 per pixel, tready=1 -> tdata 1,2,3,4 per row; tlast only on 16th beat; Done_1row 4 pulses.
- 3 channels, each pass 256 per pixel, FRAC_SHIFT=8 -> every output 3; no tvalid during first two passes.
- Saturation: conv_result 0x7FFF_0000 -> tdata 0x7FFF; 0x8000_0000 -> 0x8000 (0x0000 with OUTPUT_RELU_EN).
- tready held low 10 cycles during last pass -> exactly 2 pixels accepted, conv_ready=0 thereafter, no data lost or duplicated after release.
- Random tready/conv_valid, IMAGE_SIZE=8, 4 channels vs reference model -> bit-exact stream, tlast count 1.
- Reset asserted mid last pass with FIFO full -> next cycle tvalid=0, col=row=0; subsequent image correct.
